// File: rtl/sort_stream_packer_pkg.sv
// Shared constants and FSM encoding for the sorter front-end packer.
package sort_stream_packer_pkg;
  localparam int ARRAYWIDTH          = 8;
  localparam int OUTPUT_BUF_DATASIZE = 16;
  localparam int SORT_CYCLES_DEF     = ARRAYWIDTH + 2;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;
endpackage

// File: rtl/sort_slot_regfile.sv
// Slot storage feeding the sorter: indexed write, clear-from-index pad, full clear.
module sort_slot_regfile #(
  parameter int ARRAY_W = 8,
  parameter int DATA_W  = 16,
  parameter int CNT_W   = $clog2(ARRAY_W + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr_i,
  input  logic                      we_i,
  input  logic [CNT_W-1:0]          widx_i,
  input  logic [DATA_W-1:0]         wdata_i,
  input  logic                      pad_i,
  input  logic [CNT_W-1:0]          pad_from_i,
  output logic [ARRAY_W*DATA_W-1:0] vec_o
);
  logic [ARRAY_W-1:0][DATA_W-1:0] slot_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q <= '0;
    end else begin
      for (int k = 0; k < ARRAY_W; k++) begin
        if (clr_i)
          slot_q[k] <= '0;
        else if (we_i && widx_i == CNT_W'(k))
          slot_q[k] <= wdata_i;
        else if (pad_i && CNT_W'(k) >= pad_from_i)
          slot_q[k] <= '0;
      end
    end
  end

  assign vec_o = slot_q;
endmodule

// File: rtl/sort_stream_packer.sv
// Streams elements into the sorter's parallel vector, runs it, and returns the batch max.
module sort_stream_packer
  import sort_stream_packer_pkg::*;
#(
  parameter int ARRAY_W     = ARRAYWIDTH,
  parameter int DATA_W      = OUTPUT_BUF_DATASIZE,
  parameter int SORT_CYCLES = ARRAY_W + 2,
  localparam int CNT_W      = $clog2(ARRAY_W + 1),
  localparam int RUN_W      = $clog2(SORT_CYCLES + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DATA_W-1:0]         s_data,
  input  logic                      s_last,
  output logic                      sort_en,
  output logic [ARRAY_W*DATA_W-1:0] sort_in,
  input  logic [DATA_W-1:0]         sort_max,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_W-1:0]         m_max,
  output logic                      busy
);
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RUN_W-1:0]    run_cnt_q, run_cnt_d;
  logic                sort_en_q, sort_en_d;
  logic                m_valid_q, m_valid_d;
  logic [DATA_W-1:0]   m_max_q, m_max_d;
  logic                busy_q;
  logic                beat, close, we, pad, clr;

  assign s_ready = (state_q == FILL);
  assign beat    = s_valid & s_ready;
  assign close   = beat & ((cnt_q == CNT_W'(ARRAY_W - 1)) | s_last);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    run_cnt_d = run_cnt_q;
    sort_en_d = sort_en_q;
    m_valid_d = m_valid_q;
    m_max_d   = m_max_q;
    we        = 1'b0;
    pad       = 1'b0;
    clr       = 1'b0;
    case (state_q)
      FILL: begin
        if (beat) begin
          we = 1'b1;
          if (close) begin
            // cnt stays on the last written slot; it is cleared on handshake
            pad       = 1'b1;
            state_d   = RUN;
            run_cnt_d = '0;
            sort_en_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      RUN: begin
        if (run_cnt_q == RUN_W'(SORT_CYCLES - 1)) begin
          m_max_d   = sort_max;
          m_valid_d = 1'b1;
          sort_en_d = 1'b0;
          state_d   = HOLD;
        end else begin
          run_cnt_d = run_cnt_q + RUN_W'(1);
        end
      end
      HOLD: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          clr       = 1'b1;
          cnt_d     = '0;
          state_d   = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      run_cnt_q <= '0;
      sort_en_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_max_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      run_cnt_q <= run_cnt_d;
      sort_en_q <= sort_en_d;
      m_valid_q <= m_valid_d;
      m_max_q   <= m_max_d;
      busy_q    <= (state_d != FILL);
    end
  end

  sort_slot_regfile #(
    .ARRAY_W(ARRAY_W),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_slots (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (clr),
    .we_i      (we),
    .widx_i    (cnt_q),
    .wdata_i   (s_data),
    .pad_i     (pad),
    .pad_from_i(cnt_q + CNT_W'(1)),
    .vec_o     (sort_in)
  );

  assign sort_en = sort_en_q;
  assign m_valid = m_valid_q;
  assign m_max   = m_max_q;
  assign busy    = busy_q;
endmodule
